// File: rtl/ntt_stage_scheduler.sv
// rtl/ntt_stage_scheduler.sv - run-level start/done handshake controller for the NTT child tasks
// Launches every child task per transform, repeats for num_polys transforms, aborts on watchdog.
module ntt_stage_scheduler #(
   parameter int NUM_TASKS      = 12,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic                 ap_start,
   output logic                 ap_ready,
   output logic                 ap_done,
   output logic                 ap_idle,
   input  logic [CNT_W-1:0]     num_polys,
   output logic [NUM_TASKS-1:0] task_ap_start,
   input  logic [NUM_TASKS-1:0] task_ap_ready,
   input  logic [NUM_TASKS-1:0] task_ap_done,
   output logic [NUM_TASKS-1:0] task_ap_continue,
   output logic [CNT_W-1:0]     poly_count,
   output logic                 timeout_err
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [NUM_TASKS-1:0] started_q, started_d, done_q, done_d, cont_q;
   logic [NUM_TASKS-1:0] accept, started_nx, done_nx;
   logic [CNT_W-1:0]     target_q, target_d, count_q, count_d, count_inc;
   logic [WD_W-1:0]      wd_q, wd_d;
   logic                 err_q, err_d;
   logic                 event_seen, iter_done, wd_expired;

   assign task_ap_start    = (state_q == S_RUN) ? ~started_q : '0;
   assign task_ap_continue = cont_q;
   assign ap_done          = (state_q == S_DONE);
   assign ap_ready         = (state_q == S_DONE);
   assign ap_idle          = (state_q == S_IDLE);
   assign poly_count       = count_q;
   assign timeout_err      = err_q;

   // Completion looks at the masks including this cycle's events, so the
   // next iteration (or DONE) follows the last child event by one cycle.
   always_comb begin
      accept     = task_ap_start & task_ap_ready;
      started_nx = started_q | accept;
      done_nx    = done_q | task_ap_done;
      event_seen = (|accept) | (|task_ap_done);
      iter_done  = (&started_nx) & (&done_nx);
      count_inc  = count_q + CNT_W'(1);
      wd_expired = WD_EN && !event_seen && (wd_q == WD_LIMIT);
   end

   always_comb begin
      state_d   = state_q;
      started_d = started_q;
      done_d    = done_q;
      target_d  = target_q;
      count_d   = count_q;
      wd_d      = wd_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               target_d  = (num_polys == '0) ? CNT_W'(1) : num_polys;
               count_d   = '0;
               err_d     = 1'b0;
               started_d = '0;
               done_d    = '0;
               wd_d      = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            started_d = started_nx;
            done_d    = done_nx;
            wd_d      = event_seen ? '0 : wd_q + WD_W'(1);
            if (iter_done) begin
               count_d   = count_inc;
               started_d = '0;
               done_d    = '0;
               wd_d      = '0;
               if (count_inc == target_q) state_d = S_DONE;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q   <= S_IDLE;
         started_q <= '0;
         done_q    <= '0;
         cont_q    <= '0;
         target_q  <= '0;
         count_q   <= '0;
         wd_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= started_d;
         done_q    <= done_d;
         cont_q    <= task_ap_done;
         target_q  <= target_d;
         count_q   <= count_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// tb/tb_ntt_stage_scheduler.sv - self-checking bench for ntt_stage_scheduler
// Child tasks follow per-iteration ready/done schedules; expected outputs come from those schedules.
module tb_ntt_stage_scheduler;

   localparam int NT  = 12;
   localparam int CW  = 16;
   localparam int TMO = 100;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic          ap_start;
   logic          ap_ready, ap_done, ap_idle;
   logic [CW-1:0] num_polys;
   logic [NT-1:0] task_ap_start, task_ap_ready, task_ap_done, task_ap_continue;
   logic [CW-1:0] poly_count;
   logic          timeout_err;

   ntt_stage_scheduler #(.NUM_TASKS(NT), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_idle(ap_idle), .num_polys(num_polys),
      .task_ap_start(task_ap_start), .task_ap_ready(task_ap_ready),
      .task_ap_done(task_ap_done), .task_ap_continue(task_ap_continue),
      .poly_count(poly_count), .timeout_err(timeout_err)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int          npolys;
      int          mode;     // 0 random, 1 staggered dones, 2 late ready on task 7, 3 task 2 early, 4 task 11 hangs
      bit          hold;
      logic [15:0] exp_pc;
      logic        exp_te;
   } rec_t;

   int            errors = 0;
   int            checks = 0;
   logic [NT-1:0] prev_done = '0;
   logic          exp_te = 1'b0;
   logic [CW-1:0] last_pc = '0;
   int            sch_r[NT];
   int            sch_d[NT];
   rec_t          tab[10];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Expected continue is always the done vector driven in the previous cycle.
   task automatic expect_cycle(input string name, input logic done_e, input logic idle_e,
                               input logic [NT-1:0] start_e, input logic [CW-1:0] pc_e);
      check(name,
            {ap_done, ap_ready, ap_idle, timeout_err, task_ap_start, task_ap_continue, poly_count},
            {done_e, done_e, idle_e, exp_te, start_e, prev_done, pc_e});
   endtask

   task automatic drive(input logic [NT-1:0] rdy, input logic [NT-1:0] dn);
      task_ap_ready = rdy;
      task_ap_done  = dn;
      prev_done     = dn;
   endtask

   task automatic gen_sched(input int mode);
      for (int i = 0; i < NT; i++) begin
         case (mode)
            1: begin sch_r[i] = 0; sch_d[i] = int'($urandom_range(5, 40)); end
            2: begin
               sch_r[i] = (i == 7) ? 10 : int'($urandom_range(0, 2));
               sch_d[i] = sch_r[i] + int'($urandom_range(0, 3));
            end
            3: begin
               sch_r[i] = (i == 2) ? 0 : int'($urandom_range(1, 4));
               sch_d[i] = (i == 2) ? 0 : sch_r[i] + int'($urandom_range(1, 5));
            end
            default: begin
               sch_r[i] = int'($urandom_range(0, 6));
               sch_d[i] = int'($urandom_range(0, 10));
            end
         endcase
      end
      if (mode == 1) sch_d[$urandom_range(0, NT - 1)] = 40;
      if (mode == 4) sch_d[11] = -1;
   endtask

   task automatic run_job(input int npolys, input int mode, input bit hold);
      int            eff, last_ev, nrun;
      bit            hang;
      logic [NT-1:0] se, rdy, dn;
      logic [CW-1:0] final_pc;
      @(negedge ap_clk);
      expect_cycle("idle", 1'b0, 1'b1, '0, last_pc);
      ap_start  = 1'b1;
      num_polys = CW'(npolys);
      drive('0, '0);
      exp_te    = 1'b0;
      eff       = (npolys == 0) ? 1 : npolys;
      final_pc  = CW'(eff);
      for (int k = 0; k < eff; k++) begin
         gen_sched(mode);
         last_ev = 0;
         hang    = 1'b0;
         for (int i = 0; i < NT; i++) begin
            if (sch_r[i] > last_ev) last_ev = sch_r[i];
            if (sch_d[i] > last_ev) last_ev = sch_d[i];
            if (sch_d[i] < 0) hang = 1'b1;
         end
         nrun = hang ? last_ev + TMO + 1 : last_ev + 1;
         for (int t = 0; t < nrun; t++) begin
            @(negedge ap_clk);
            if (k == 0 && t == 0) ap_start = hold;
            for (int i = 0; i < NT; i++) begin
               se[i]  = (t <= sch_r[i]);
               rdy[i] = (t == sch_r[i]);
               dn[i]  = (t == sch_d[i]);
            end
            expect_cycle("run", 1'b0, 1'b0, se, CW'(k));
            drive(rdy, dn);
         end
         if (hang) begin
            exp_te   = 1'b1;
            final_pc = CW'(k);
            break;
         end
      end
      @(negedge ap_clk);
      expect_cycle("done", 1'b1, 1'b0, '0, final_pc);
      drive('0, (mode == 0) ? NT'($urandom) : '0);
      last_pc = final_pc;
   endtask

   initial begin
      tab[0] = '{1, 1, 1'b0, 16'd1, 1'b0};
      tab[1] = '{3, 2, 1'b0, 16'd3, 1'b0};
      tab[2] = '{1, 3, 1'b0, 16'd1, 1'b0};
      tab[3] = '{1, 4, 1'b0, 16'd0, 1'b1};
      tab[4] = '{2, 0, 1'b0, 16'd2, 1'b0};
      tab[5] = '{0, 0, 1'b1, 16'd1, 1'b0};
      tab[6] = '{0, 0, 1'b1, 16'd1, 1'b0};
      tab[7] = '{0, 0, 1'b0, 16'd1, 1'b0};
      tab[8] = '{4, 0, 1'b0, 16'd4, 1'b0};
      tab[9] = '{5, 3, 1'b0, 16'd5, 1'b0};

      ap_rst_n      = 1'b0;
      ap_start      = 1'b0;
      num_polys     = '0;
      task_ap_ready = '0;
      task_ap_done  = '0;
      repeat (2) @(negedge ap_clk);
      expect_cycle("reset", 1'b0, 1'b1, '0, '0);
      ap_rst_n = 1'b1;

      for (int j = 0; j < 10; j++) begin
         run_job(tab[j].npolys, tab[j].mode, tab[j].hold);
         check("rec_poly_count", 64'(poly_count), 64'(tab[j].exp_pc));
         check("rec_timeout_err", 64'(timeout_err), 64'(tab[j].exp_te));
      end
      for (int j = 0; j < 6; j++) run_job(int'($urandom_range(0, 4)), 0, 1'b0);

      // Asynchronous reset after 3 of 12 tasks accepted in the second iteration.
      @(negedge ap_clk);
      ap_start  = 1'b1;
      num_polys = 16'd2;
      drive('0, '0);
      @(negedge ap_clk);
      ap_start = 1'b0;
      drive('1, '1);
      @(negedge ap_clk);
      check("mid_start_all", 64'(task_ap_start), 64'hFFF);
      check("mid_poly_count", 64'(poly_count), 64'd1);
      drive(12'h007, '0);
      @(negedge ap_clk);
      check("mid_three_ready", 64'(task_ap_start), 64'hFF8);
      drive('0, '0);
      #2 ap_rst_n = 1'b0;
      #1;
      check("arst_task_start", 64'(task_ap_start), 64'd0);
      check("arst_idle", 64'(ap_idle), 64'd1);
      check("arst_poly_count", 64'(poly_count), 64'd0);
      check("arst_done", 64'({ap_done, ap_ready, timeout_err}), 64'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      last_pc  = '0;
      prev_done = '0;
      exp_te   = 1'b0;
      run_job(2, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
